// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier: one add/sub-and-shift substep per clock, valid/ready handshakes.
// Define MUL_OVF_FLAG_EN to add the ovf output (product does not fit in N bits of the selected mode).
//
// state  | meaning
// S_IDLE | waiting for operands, in_ready high
// S_CALC | N+1 Booth substeps, one per cycle
// S_DONE | product valid and held until out_ready
module booth_mult_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           is_signed,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
`ifdef MUL_OVF_FLAG_EN
    output logic           ovf,
`endif
    output logic           busy
);
    localparam int W  = N + 1;
    localparam int CW = $clog2(N + 2);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, q_q, q_d, m_q, m_d;
    logic           q0_q, q0_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] product_q, product_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q, busy_d;
    logic [W-1:0]   sum, a_n, q_n;
    logic [2*N-1:0] prod_n;
`ifdef MUL_OVF_FLAG_EN
    logic           sgn_q, sgn_d;
    logic           ovf_q, ovf_d;
`endif

    // One Booth substep: recode {Q[0],q0}, add/sub M into A, then arithmetic shift {A,Q,q0}.
    always_comb begin
        case ({q_q[0], q0_q})
            2'b10:   sum = a_q - m_q;
            2'b01:   sum = a_q + m_q;
            default: sum = a_q;
        endcase
        a_n    = {sum[W-1], sum[W-1:1]};
        q_n    = {sum[0], q_q[W-1:1]};
        prod_n = {a_n[N-2:0], q_n};
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        q0_d      = q0_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
`ifdef MUL_OVF_FLAG_EN
        sgn_d     = sgn_q;
        ovf_d     = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = '0;
                    q0_d    = 1'b0;
                    m_d     = {is_signed & multiplicand[N-1], multiplicand};
                    q_d     = {is_signed & multiplier[N-1], multiplier};
                    cnt_d   = CW'(N + 1);
`ifdef MUL_OVF_FLAG_EN
                    sgn_d   = is_signed;
`endif
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                a_d   = a_n;
                q_d   = q_n;
                q0_d  = q_q[0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    product_d = prod_n;
`ifdef MUL_OVF_FLAG_EN
                    if (sgn_q)
                        ovf_d = !((&prod_n[2*N-1:N-1]) || !(|prod_n[2*N-1:N-1]));
                    else
                        ovf_d = |prod_n[2*N-1:N];
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            q_q         <= '0;
            q0_q        <= 1'b0;
            m_q         <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MUL_OVF_FLAG_EN
            sgn_q       <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            q0_q        <= q0_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef MUL_OVF_FLAG_EN
            sgn_q       <= sgn_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = product_q;
`ifdef MUL_OVF_FLAG_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_booth_mult_seq.sv
// Testbench for booth_mult_seq: directed vector table, handshake/reset corner sequences,
// and randomized back-to-back traffic against an arithmetic reference model.
module tb_booth_mult_seq;
    localparam int N   = 8;
    localparam int LAT = N + 1;
    localparam int NV  = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           is_signed = 1'b0;
    logic [N-1:0]   multiplicand = '0;
    logic [N-1:0]   multiplier = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] product;
    logic           busy;
`ifdef MUL_OVF_FLAG_EN
    logic           ovf;
`endif

    int vectors = 0;
    int miscompares = 0;

    booth_mult_seq #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .is_signed    (is_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
`ifdef MUL_OVF_FLAG_EN
        .ovf          (ovf),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic           s;
        logic [N-1:0]   m;
        logic [N-1:0]   q;
        logic [2*N-1:0] p;
        logic           o;
    } vec_t;

    vec_t tbl[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Reference: plain integer product of the operands interpreted in the selected mode.
    function automatic logic [2*N:0] ref_mul(input logic s, input logic [N-1:0] m, input logic [N-1:0] q);
        longint a, b, p;
        logic   o;
        a = s ? longint'($signed(m)) : longint'(m);
        b = s ? longint'($signed(q)) : longint'(q);
        p = a * b;
        if (s)
            o = (p < -(longint'(1) << (N - 1))) || (p >= (longint'(1) << (N - 1)));
        else
            o = (p >= (longint'(1) << N));
        return {o, p[2*N-1:0]};
    endfunction

    function automatic logic [N-1:0] pick();
        case ($urandom_range(7, 0))
            0:       return '0;
            1:       return {1'b1, {(N-1){1'b0}}};
            2:       return '1;
            3:       return {1'b0, {(N-1){1'b1}}};
            default: return N'($urandom);
        endcase
    endfunction

    task automatic accept(input logic s, input logic [N-1:0] m, input logic [N-1:0] q);
        int t;
        t = 0;
        is_signed = s;
        multiplicand = m;
        multiplier = q;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) fail_bound("accept_wait");
        @(posedge clk); #1;
        in_valid = 1'b0;
        is_signed = 1'($urandom);
        multiplicand = N'($urandom);
        multiplier = N'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Monitor for the randomized phase; handshakes are sampled on the falling edge.
    logic [2*N:0] exp_q[$];
    logic [2*N:0] mon_e;
    bit           mon_en = 1'b0;
    int           cyc = 0, n_acc = 0, n_out = 0, first_acc = 0, last_acc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_en) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_mul(is_signed, multiplicand, multiplier));
                if (n_acc == 0) first_acc = cyc;
                last_acc = cyc;
                n_acc++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rand_extra_out: got product 0x%0h, expected no output", product);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rand_product", 32'(product), 32'(mon_e[2*N-1:0]));
`ifdef MUL_OVF_FLAG_EN
                    check("rand_ovf", 32'(ovf), 32'(mon_e[2*N]));
`endif
                end
            end
        end
    end

    initial begin
        int lat, t, spurious;

        tbl[0]  = '{1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b0};
        tbl[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b1};
        tbl[2]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0};
        tbl[3]  = '{1'b1, 8'h80, 8'h80, 16'h4000, 1'b1};
        tbl[4]  = '{1'b1, 8'h10, 8'h08, 16'h0080, 1'b1};
        tbl[5]  = '{1'b0, 8'h0F, 8'h11, 16'h00FF, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 8'h5A, 16'h0000, 1'b0};
        tbl[7]  = '{1'b1, 8'h7F, 8'h00, 16'h0000, 1'b0};
        tbl[8]  = '{1'b1, 8'h7F, 8'h80, 16'hC080, 1'b1};
        tbl[9]  = '{1'b0, 8'h80, 8'h80, 16'h4000, 1'b1};
        tbl[10] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01, 1'b1};
        tbl[11] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF, 1'b0};
        tbl[12] = '{1'b0, 8'hFF, 8'h01, 16'h00FF, 1'b0};
        tbl[13] = '{1'b1, 8'hF4, 8'hF4, 16'h0090, 1'b1};
        tbl[14] = '{1'b1, 8'h80, 8'h01, 16'hFF80, 1'b0};
        tbl[15] = '{1'b1, 8'h80, 8'hFF, 16'h0080, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_product", 32'(product), 0);
`ifdef MUL_OVF_FLAG_EN
        check("rst_ovf", 32'(ovf), 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            accept(tbl[i].s, tbl[i].m, tbl[i].q);
            check($sformatf("vec%0d_busy", i), 32'(busy), 1);
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 0);
            wait_done(lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
            check($sformatf("vec%0d_product", i), 32'(product), 32'(tbl[i].p));
`ifdef MUL_OVF_FLAG_EN
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(tbl[i].o));
`endif
            release_out();
            check($sformatf("vec%0d_out_valid_clr", i), 32'(out_valid), 0);
            check($sformatf("vec%0d_in_ready_ret", i), 32'(in_ready), 1);
        end

        // Backpressure in DONE: output held, new operands ignored
        accept(1'b0, 8'h23, 8'h11);
        wait_done(lat);
        check("hold_latency", 32'(lat), 32'(LAT));
        in_valid = 1'b1;
        is_signed = 1'b1;
        multiplicand = 8'h55;
        multiplier = 8'h55;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_out_valid", c), 32'(out_valid), 1);
            check($sformatf("hold%0d_product", c), 32'(product), 32'h0253);
            check($sformatf("hold%0d_in_ready", c), 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        release_out();
        check("hold_rel_in_ready", 32'(in_ready), 1);
        check("hold_rel_out_valid", 32'(out_valid), 0);
        accept(1'b1, 8'h0C, 8'hF4);
        wait_done(lat);
        check("hold_next_latency", 32'(lat), 32'(LAT));
        check("hold_next_product", 32'(product), 32'hFF70);
`ifdef MUL_OVF_FLAG_EN
        check("hold_next_ovf", 32'(ovf), 1);
`endif
        release_out();

        // Asynchronous reset in the middle of CALC
        accept(1'b0, 8'h31, 8'h02);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        check("arst_busy", 32'(busy), 0);
        check("arst_product", 32'(product), 0);
`ifdef MUL_OVF_FLAG_EN
        check("arst_ovf", 32'(ovf), 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        spurious = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) spurious++;
        end
        check("arst_no_out_valid", 32'(spurious), 0);
        accept(1'b0, 8'h07, 8'h06);
        wait_done(lat);
        check("arst_after_latency", 32'(lat), 32'(LAT));
        check("arst_after_product", 32'(product), 32'h002A);
        release_out();

        // Randomized back-to-back traffic with out_ready tied high
        @(posedge clk); #1;
        mon_en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            is_signed = 1'($urandom);
            multiplicand = pick();
            multiplier = pick();
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            if (!in_ready) fail_bound("rand_accept_wait");
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        out_ready = 1'b0;
        check("rand_accepts", 32'(n_acc), 1000);
        check("rand_outputs", 32'(n_out), 32'(n_acc));
        check("rand_pending", 32'(exp_q.size()), 0);
        check("rand_throughput", 32'(last_acc - first_acc), 32'(999 * (N + 3)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
